lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the single-cycle core datapath and the word-wide synchronous data memory (1-cycle read latency, write on the clock edge).
- Converts byte-addressed RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
  - Sub-word stores use read-modify-write.
  - Loads are sign- or zero-extended.
  - Misaligned and illegal accesses are flagged and never touch memory.
- Single outstanding request, with a valid/ready request and a pulsed response.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 35 +++
 rtl/lsu_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and lane helpers for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_LD_RD,
    S_LD_CAP,
    S_RMW_RD,
    S_RMW_MRG,
    S_ST_WR,
    S_RESP
  } state_t;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Bit offset of a little-endian byte lane within the word
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extract/extend for loads and byte/half merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_merged
);

  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  // Addressed lane moved down to bit 0; alignment was already checked upstream
  assign w_shifted = i_rword >> lane_shift(i_lane);

  // Load extension by width and signedness
  always_comb begin
    o_ldata = w_shifted;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_ldata = w_shifted & BYTE_MASK;
      F3_HU:   o_ldata = w_shifted & HALF_MASK;
      default: o_ldata = w_shifted;
    endcase
  end

  // Store merge: replace only the addressed byte or half of the old word
  assign w_mask   = ((i_funct3 == F3_H) ? HALF_MASK : BYTE_MASK) << lane_shift(i_lane);
  assign o_merged = (i_rword & ~w_mask) | ((i_wdata << lane_shift(i_lane)) & w_mask);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding RV32 load/store controller over a word memory
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [2:0]    i_req_funct3,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_mem_we,
  output logic [N-1:0]  o_mem_a,
  output logic [31:0]   o_mem_wd,
  input  logic [31:0]   i_mem_rd
);

  if (M != 32) begin : g_bad_width
    $error("lsu_mem_ctrl supports only M == 32");
  end

  state_t        r_state;
  logic [N+1:0]  r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_wd;
  logic [31:0]   r_rdata;
  logic [2:0]    r_funct3;
  logic          r_we;
  logic          r_err;

  logic          w_accept;
  logic          w_misaligned;
  logic          w_illegal;
  logic [31:0]   w_ldata;
  logic [31:0]   w_merged;
  logic          w_unused_addr;

  // Upper address bits wrap around the 2^N-word memory
  assign w_unused_addr = ^i_req_addr[31:N+2];

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  // Request legality, judged on the incoming request at acceptance
  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    case (i_req_funct3)
      F3_H, F3_HU: w_misaligned = i_req_addr[0];
      F3_W:        w_misaligned = (i_req_addr[1:0] != 2'b00);
      default:     w_misaligned = 1'b0;
    endcase
    if (i_req_funct3 == 3'b011 || i_req_funct3 == 3'b110 || i_req_funct3 == 3'b111)
      w_illegal = 1'b1;
    if (i_req_we && !(i_req_funct3 == F3_B || i_req_funct3 == F3_H || i_req_funct3 == F3_W))
      w_illegal = 1'b1;
  end

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_addr[1:0]),
    .i_rword  (i_mem_rd),
    .i_wdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_merged (w_merged)
  );

  // Request sequencing: accept, access memory, then pulse one response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= i_req_addr[N+1:0];
            r_wdata  <= i_req_wdata;
            r_funct3 <= i_req_funct3;
            r_we     <= i_req_we;
            if (w_misaligned || w_illegal) begin
              r_state <= S_ERR;
            end else if (!i_req_we) begin
              r_state <= S_LD_RD;
            end else if (i_req_funct3 == F3_W) begin
              r_wd    <= i_req_wdata;
              r_state <= S_ST_WR;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_ERR: begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= S_RESP;
        end
        S_LD_RD:  r_state <= S_LD_CAP;
        S_LD_CAP: begin
          r_rdata <= w_ldata;
          r_err   <= 1'b0;
          r_state <= S_RESP;
        end
        S_RMW_RD: r_state <= S_RMW_MRG;
        S_RMW_MRG: begin
          r_wd    <= w_merged;
          r_state <= S_ST_WR;
        end
        S_ST_WR: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_RESP;
        end
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_mem_we    = (r_state == S_ST_WR) && r_we;
  assign o_mem_a     = r_addr[N+1:2];
  assign o_mem_wd    = o_mem_we ? r_wd : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  localparam int N = 10;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [N-1:0]  mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  logic [31:0]   mem [0:(1<<N)-1];
  int            checks;
  int            errors;
  int            we_cnt;
  int            rsp_cnt;
  logic [31:0]   last_wa;
  logic [31:0]   last_wd;
  int            w0;
  int            r0;

  lsu_mem_ctrl #(.N(N), .M(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_mem_we     (mem_we),
    .o_mem_a      (mem_a),
    .o_mem_wd     (mem_wd),
    .i_mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: write on the edge, registered read (old data)
  always @(posedge clk) begin
    mem_rd <= mem[mem_a];
    if (mem_we) begin
      mem[mem_a] <= mem_wd;
      we_cnt  = we_cnt + 1;
      last_wa = 32'(mem_a);
      last_wd = mem_wd;
    end
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int guard;
    int lat;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      chk({tag, " busy"}, 32'(req_ready), 32'd0);
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, rsp_rdata, exp_rdata);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_a"}, 32'(mem_a), 32'd0);
    chk({tag, " mem_wd"}, mem_wd, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; we_cnt = 0; rsp_cnt = 0;
    last_wa = '0; last_wd = '0;
    for (int i = 0; i < (1<<N); i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // SW then LW of the same word
    w0 = we_cnt;
    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2, 32'h0, 1'b0);
    chk("sw10 we count", 32'(we_cnt - w0), 32'd1);
    chk("sw10 mem_a", last_wa, 32'd4);
    chk("sw10 mem_wd", last_wd, 32'hDEADBEEF);
    chk("sw10 mem", mem[4], 32'hDEADBEEF);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0);

    // Byte store into lane 3, then signed and unsigned byte loads
    mem[4] = 32'h11223344;
    do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0, 4, 32'h0, 1'b0);
    chk("sb13 mem", mem[4], 32'hAA223344);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 3, 32'hFFFFFFAA, 1'b0);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 3, 32'h000000AA, 1'b0);

    // Half store into upper half, then signed and unsigned half loads
    mem[5] = 32'h0;
    do_req("sh16", 1'b1, 3'b001, 32'h16, 32'h00008001, 1'b0, 4, 32'h0, 1'b0);
    chk("sh16 mem", mem[5], 32'h80010000);
    do_req("lh16", 1'b0, 3'b001, 32'h16, 32'h0, 1'b0, 3, 32'hFFFF8001, 1'b0);
    do_req("lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 1'b0, 3, 32'h00008001, 1'b0);

    // Misaligned and illegal requests never touch memory
    w0 = we_cnt;
    do_req("lw02", 1'b0, 3'b010, 32'h02, 32'h0, 1'b0, 2, 32'h0, 1'b1);
    do_req("sh15", 1'b1, 3'b001, 32'h15, 32'hFFFFFFFF, 1'b0, 2, 32'h0, 1'b1);
    do_req("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 1'b0, 2, 32'h0, 1'b1);
    do_req("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h12345678, 1'b0, 2, 32'h0, 1'b1);
    chk("err we count", 32'(we_cnt - w0), 32'd0);
    chk("err mem5", mem[5], 32'h80010000);
    chk("err mem8", mem[8], 32'h0);

    // Reset while the SB merge is in flight
    mem[4] = 32'h11223344;
    w0 = we_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h13; req_wdata = 32'h000000AA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst we count", 32'(we_cnt - w0), 32'd0);
    chk("midrst mem", mem[4], 32'h11223344);
    chk("midrst ready", 32'(req_ready), 32'd1);

    // Back-to-back loads with valid held; 0x1000 aliases word 0
    mem[0] = 32'hCAFEF00D;
    r0 = rsp_cnt;
    do_req("b2b_1000", 1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 3, 32'hCAFEF00D, 1'b0);
    do_req("b2b_0000", 1'b0, 3'b010, 32'h0000, 32'h0, 1'b1, 3, 32'hCAFEF00D, 1'b0);
    do_req("b2b_0010", 1'b0, 3'b010, 32'h0010, 32'h0, 1'b0, 3, 32'h11223344, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b rsp count", 32'(rsp_cnt - r0), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
